// File: rtl/cmp_result_monitor.sv
// Qualifies comparator less/equal/greater flags into a debounced, hysteretic result,
// with saturating per-result tallies and a sticky non-one-hot error.
module cmp_result_monitor #(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             lt_in,
    input  logic             eq_in,
    input  logic             gt_in,
    input  logic             clr,
    output logic             stable_vld,
    output logic [1:0]       stable_code,
    output logic             change_pls,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CAND   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] STABLE_RUN = 4'(STABLE_CNT);
    localparam logic [1:0] CODE_LT    = 2'b01;
    localparam logic [1:0] CODE_EQ    = 2'b10;
    localparam logic [1:0] CODE_GT    = 2'b11;

    state_t     state, state_nxt;
    logic [1:0] cand, cand_nxt;
    logic [3:0] run, run_nxt, run_inc;
    logic [1:0] ones;
    logic [1:0] code;
    logic       good, bad;
    logic       lock_evt;

    assign ones    = {1'b0, lt_in} + {1'b0, eq_in} + {1'b0, gt_in};
    assign good    = in_valid && (ones == 2'd1);
    assign bad     = in_valid && (ones != 2'd1);
    assign code    = lt_in ? CODE_LT : (eq_in ? CODE_EQ : CODE_GT);
    assign run_inc = run + 4'd1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cand  <= '0;
            run   <= '0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            run   <= run_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        run_nxt   = run;
        lock_evt  = 1'b0;
        if (good) begin
            unique case (state)
                IDLE: begin
                    state_nxt = CAND;
                    cand_nxt  = code;
                    run_nxt   = 4'd1;
                end
                CAND: begin
                    if (code == cand) begin
                        run_nxt = run_inc;
                        if (run_inc == STABLE_RUN) begin
                            state_nxt = LOCKED;
                            lock_evt  = 1'b1;
                        end
                    end else begin
                        cand_nxt = code;
                        run_nxt  = 4'd1;
                    end
                end
                LOCKED: begin
                    // Held result stays on the outputs until the new run itself locks.
                    if (code != stable_code) begin
                        state_nxt = CAND;
                        cand_nxt  = code;
                        run_nxt   = 4'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (bad && state == CAND) begin
            state_nxt = IDLE;
            cand_nxt  = '0;
            run_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_vld  <= 1'b0;
            stable_code <= '0;
            change_pls  <= 1'b0;
        end else begin
            change_pls <= lock_evt && (cand != stable_code);
            if (lock_evt) begin
                stable_code <= cand;
                stable_vld  <= 1'b1;
            end
        end
    end

    // clr suppresses counting of a same-cycle sample; the FSM above still sees it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lt_cnt   <= '0;
            eq_cnt   <= '0;
            gt_cnt   <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            if (good && code == CODE_LT) lt_cnt <= sat_inc(lt_cnt);
            if (good && code == CODE_EQ) eq_cnt <= sat_inc(eq_cnt);
            if (good && code == CODE_GT) gt_cnt <= sat_inc(gt_cnt);
            if (bad) begin
                err_cnt  <= sat_inc(err_cnt);
                err_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Self-checking bench for cmp_result_monitor: vector table, hand sequences and a
// queued reference model compared every cycle.
module tb_cmp_result_monitor;

    localparam int unsigned SC = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, lt_in = 1'b0, eq_in = 1'b0, gt_in = 1'b0, clr = 1'b0;
    logic          stable_vld, change_pls, err_flag;
    logic [1:0]    stable_code;
    logic [CW-1:0] lt_cnt, eq_cnt, gt_cnt, err_cnt;

    cmp_result_monitor #(.STABLE_CNT(SC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .lt_in(lt_in), .eq_in(eq_in),
        .gt_in(gt_in), .clr(clr), .stable_vld(stable_vld), .stable_code(stable_code),
        .change_pls(change_pls), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .gt_cnt(gt_cnt),
        .err_flag(err_flag), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef logic [20:0] obs_t;
    obs_t exp_q[$];

    // Reference model state
    bit         m_have, m_inlock, m_sv, m_pls, m_ef;
    logic [1:0] m_cand, m_sc;
    int         m_run;
    logic [CW-1:0] m_lt, m_eq, m_gt, m_err;

    function automatic obs_t pack_obs(logic sv, logic [1:0] sc, logic p, logic [CW-1:0] l,
                                      logic [CW-1:0] e, logic [CW-1:0] g, logic ef,
                                      logic [CW-1:0] er);
        return {sv, sc, p, l, e, g, ef, er};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model(input logic v, input logic l, input logic e, input logic g,
                         input logic c, input logic r);
        int n;
        logic [1:0] cd;
        if (r) begin
            m_have = 0; m_inlock = 0; m_sv = 0; m_pls = 0; m_ef = 0;
            m_cand = 0; m_sc = 0; m_run = 0;
            m_lt = 0; m_eq = 0; m_gt = 0; m_err = 0;
            return;
        end
        m_pls = 0;
        if (v) begin
            n = int'(l) + int'(e) + int'(g);
            if (n == 1) begin
                cd = l ? 2'b01 : (e ? 2'b10 : 2'b11);
                if (cd == 2'b01 && m_lt != '1) m_lt++;
                if (cd == 2'b10 && m_eq != '1) m_eq++;
                if (cd == 2'b11 && m_gt != '1) m_gt++;
                if (m_inlock) begin
                    if (cd != m_sc) begin
                        m_inlock = 0; m_have = 1; m_cand = cd; m_run = 1;
                    end
                end else if (m_have && cd == m_cand) begin
                    m_run++;
                    if (m_run == SC) begin
                        m_inlock = 1; m_have = 0;
                        m_pls = (m_cand != m_sc);
                        m_sc = m_cand; m_sv = 1;
                    end
                end else begin
                    m_have = 1; m_cand = cd; m_run = 1;
                end
            end else begin
                if (m_err != '1) m_err++;
                m_ef = 1;
                if (!m_inlock) begin m_have = 0; m_run = 0; end
            end
        end
        if (c) begin
            m_lt = 0; m_eq = 0; m_gt = 0; m_err = 0; m_ef = 0;
        end
    endtask

    // Drive one cycle, queue the model's expectation, compare after the edge.
    task automatic step(input logic v, input logic l, input logic e, input logic g,
                        input logic c, input logic r);
        obs_t act, exp_v;
        @(negedge clk);
        in_valid = v; lt_in = l; eq_in = e; gt_in = g; clr = c; rst = r;
        model(v, l, e, g, c, r);
        exp_q.push_back(pack_obs(m_sv, m_sc, m_pls, m_lt, m_eq, m_gt, m_ef, m_err));
        @(posedge clk);
        #1;
        act   = pack_obs(stable_vld, stable_code, change_pls, lt_cnt, eq_cnt, gt_cnt,
                         err_flag, err_cnt);
        exp_v = exp_q.pop_front();
        check("scoreboard", 32'(act), 32'(exp_v));
    endtask

    typedef struct {
        logic v, l, e, g, c, r;
        logic       x_sv;
        logic [1:0] x_sc;
        logic       x_p;
    } vec_t;

    vec_t tbl[19];

    initial begin
        //            v  l  e  g  c  r   sv sc     p
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,2'b00,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,2'b00,1'b0};
        tbl[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,2'b00,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,2'b00,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,2'b00,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,2'b00,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,2'b00,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,2'b00,1'b0};
        tbl[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,2'b11,1'b1};
        tbl[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,2'b11,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,2'b11,1'b0};
        tbl[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,2'b11,1'b0};
        tbl[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,2'b11,1'b0};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,2'b11,1'b0};
        tbl[14] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,2'b11,1'b0};
        tbl[15] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,2'b11,1'b0};
        tbl[16] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,2'b11,1'b0};
        tbl[17] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,2'b01,1'b1};
        tbl[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,2'b01,1'b0};

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].v, tbl[i].l, tbl[i].e, tbl[i].g, tbl[i].c, tbl[i].r);
            check($sformatf("vec%0d", i), {29'd0, stable_vld, stable_code, change_pls},
                  {29'd0, tbl[i].x_sv, tbl[i].x_sc, tbl[i].x_p});
            if (i == 1) check("reset_err", {31'd0, err_flag}, 32'd0);
            if (i == 4) check("eq_cnt_3", 32'(eq_cnt), 32'd3);
            if (i == 8) check("gt_cnt_4", 32'(gt_cnt), 32'd4);
        end
        check("lt_cnt_7", 32'(lt_cnt), 32'd7);

        // Bad sample mid-run restarts the run
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        check("err_flag_set", {31'd0, err_flag}, 32'd1);
        check("err_cnt_1", 32'(err_cnt), 32'd1);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        check("no_early_lock", 32'(stable_code), 32'd1);
        step(1, 0, 1, 0, 0, 0);
        check("relock_eq", {30'd0, stable_code}, 32'd2);
        check("relock_pls", {31'd0, change_pls}, 32'd1);
        step(0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("invalid_ignored", 32'(err_cnt), 32'd1);

        // Saturation, clear with a sample, reset mid-run
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0, 0);
        check("eq_sat", 32'(eq_cnt), 32'd15);
        step(1, 0, 0, 1, 1, 0);
        check("clr_counts", {err_flag, 4'(lt_cnt), 4'(eq_cnt), 4'(gt_cnt), 4'(err_cnt)}, 32'd0);
        check("clr_keeps_code", 32'(stable_code), 32'd2);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        check("rst_midrun", {stable_vld, stable_code, change_pls, 4'(gt_cnt)}, 32'd0);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [2:0] f;
            logic v;
            v = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 11))
                0:       f = 3'(($urandom_range(0, 7)));
                1, 2, 3: f = 3'b100;
                4, 5, 6: f = 3'b010;
                default: f = 3'b001;
            endcase
            step(v, f[2], f[1], f[0], ($urandom_range(0, 30) == 0),
                 ($urandom_range(0, 80) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
